// File: rtl/ps2_pkg.sv
// Shared definitions for the PS/2 scancode decoder: FSM state encoding,
// prefix / shift-key scancodes and the list of bytes that never form a key.
package ps2_pkg;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_EXT    = 2'd1,
    S_BRK    = 2'd2,
    S_EXTBRK = 2'd3
  } ps2_state_e;

  localparam logic [7:0] PS2_PFX_EXT = 8'hE0;
  localparam logic [7:0] PS2_PFX_BRK = 8'hF0;
  localparam logic [7:0] PS2_LSHIFT  = 8'h12;
  localparam logic [7:0] PS2_RSHIFT  = 8'h59;

  // Keyboard status / error bytes (overrun, BAT ok, ACK, error): dropped in any state.
  localparam int PS2_NUM_DISCARD = 4;
  localparam logic [7:0] PS2_DISCARD [PS2_NUM_DISCARD] = '{8'h00, 8'hAA, 8'hFA, 8'hFF};

  function automatic logic ps2_is_discard(input logic [7:0] b);
    logic hit;
    hit = 1'b0;
    for (int i = 0; i < PS2_NUM_DISCARD; i++) begin
      if (b == PS2_DISCARD[i]) hit = 1'b1;
    end
    return hit;
  endfunction

endpackage

// File: rtl/ps2_scancode_decoder_if.sv
// Bundle between the upstream PS/2 receiver FIFO, the decoder and the key
// event consumer.
//
// FIFO handshake: ps2_ready is high while the FIFO holds a byte and ps2_data
// shows the head byte. The decoder takes the byte in a cycle where it sees
// ps2_ready high and has no pop outstanding, then drives ps2_read_n low for
// exactly the following cycle; the FIFO advances its read pointer on that
// cycle's rising edge. ps2_read_n is never low two cycles in a row, so
// ps2_ready/ps2_data are always re-settled before the next byte is taken.
// key_valid and proto_err are single-cycle pulses; the remaining key_* fields
// hold until the next event. fsm_state exposes the prefix FSM for debug.
interface ps2_scancode_decoder_if
  import ps2_pkg::*;
#(
  parameter int COUNT_W = 8
);
  logic               ps2_ready;
  logic [7:0]         ps2_data;
  logic               ps2_read_n;
  logic               key_valid;
  logic [7:0]         key_code;
  logic               key_ext;
  logic               key_release;
  logic               key_repeat;
  logic [7:0]         key_ascii;
  logic               shift_held;
  logic [COUNT_W-1:0] key_count;
  logic               proto_err;
  ps2_state_e         fsm_state;

  modport master (
    input  ps2_ready, ps2_data,
    output ps2_read_n, key_valid, key_code, key_ext, key_release, key_repeat,
           key_ascii, shift_held, key_count, proto_err, fsm_state
  );

  modport slave (
    output ps2_ready, ps2_data,
    input  ps2_read_n, key_valid, key_code, key_ext, key_release, key_repeat,
           key_ascii, shift_held, key_count, proto_err, fsm_state
  );
endinterface

// File: rtl/ps2_scancode_ascii.sv
// Combinational set-2 scancode to ASCII map: letters (case follows shift),
// top-row digits, space and enter. Everything else maps to 0x00.
module ps2_scancode_ascii (
  input  logic [7:0] code,
  input  logic       shift,
  output logic [7:0] ascii
);

  logic [7:0] letter;

  // Letters first (lower case, 0 when not a letter), then the other keys.
  always_comb begin
    letter = 8'h00;
    ascii  = 8'h00;
    case (code)
      8'h1C: letter = 8'h61; 8'h32: letter = 8'h62; 8'h21: letter = 8'h63;
      8'h23: letter = 8'h64; 8'h24: letter = 8'h65; 8'h2B: letter = 8'h66;
      8'h34: letter = 8'h67; 8'h33: letter = 8'h68; 8'h43: letter = 8'h69;
      8'h3B: letter = 8'h6A; 8'h42: letter = 8'h6B; 8'h4B: letter = 8'h6C;
      8'h3A: letter = 8'h6D; 8'h31: letter = 8'h6E; 8'h44: letter = 8'h6F;
      8'h4D: letter = 8'h70; 8'h15: letter = 8'h71; 8'h2D: letter = 8'h72;
      8'h1B: letter = 8'h73; 8'h2C: letter = 8'h74; 8'h3C: letter = 8'h75;
      8'h2A: letter = 8'h76; 8'h1D: letter = 8'h77; 8'h22: letter = 8'h78;
      8'h35: letter = 8'h79; 8'h1A: letter = 8'h7A;
      default: letter = 8'h00;
    endcase
    if (letter != 8'h00) begin
      ascii = shift ? (letter - 8'h20) : letter;
    end else begin
      case (code)
        8'h45: ascii = 8'h30; 8'h16: ascii = 8'h31; 8'h1E: ascii = 8'h32;
        8'h26: ascii = 8'h33; 8'h25: ascii = 8'h34; 8'h2E: ascii = 8'h35;
        8'h36: ascii = 8'h36; 8'h3D: ascii = 8'h37; 8'h3E: ascii = 8'h38;
        8'h46: ascii = 8'h39;
        8'h29: ascii = 8'h20;
        8'h5A: ascii = 8'h0D;
        default: ascii = 8'h00;
      endcase
    end
  end

endmodule

// File: rtl/ps2_scancode_decoder.sv
// PS/2 set-2 scancode decoder: pops bytes from the receiver FIFO, strips the
// E0/F0 prefixes, and emits one registered key event per scancode with
// repeat detection, shift tracking and a make counter.
// Build option: define PS2_DECODER_ASCII_EN to add the ASCII mapping on
// key_ascii; without it key_ascii is tied to 0x00.
module ps2_scancode_decoder
  import ps2_pkg::*;
#(
  parameter int COUNT_W = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  ps2_scancode_decoder_if.master bus
);

  logic               pop;
  logic               pop_q;
  logic [7:0]         byte_in;
  ps2_state_e         state_q;
  ps2_state_e         state_d;
  logic               ev_d;
  logic               ev_ext_d;
  logic               ev_rel_d;
  logic               perr_d;
  logic               held_match;
  logic               repeat_d;
  logic [7:0]         held_code_q;
  logic               held_ext_q;
  logic               held_vld_q;
  logic               shift_l_q;
  logic               shift_r_q;
  logic               shift_held;
  logic               key_valid_q;
  logic [7:0]         key_code_q;
  logic               key_ext_q;
  logic               key_release_q;
  logic               key_repeat_q;
  logic               proto_err_q;
  logic [COUNT_W-1:0] key_count_q;

  // A pop is only allowed when none was issued last cycle.
  assign pop     = bus.ps2_ready & ~pop_q;
  assign byte_in = bus.ps2_data;

  // Prefix FSM state register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next state and event decode for the byte being popped this cycle.
  always_comb begin
    state_d  = state_q;
    ev_d     = 1'b0;
    ev_ext_d = 1'b0;
    ev_rel_d = 1'b0;
    perr_d   = 1'b0;
    if (pop) begin
      if (ps2_is_discard(byte_in)) begin
        state_d = S_IDLE;
      end else if (byte_in == PS2_PFX_EXT) begin
        // E0 after a break prefix is out of order; restart as an extended code.
        state_d = S_EXT;
        perr_d  = (state_q == S_BRK) || (state_q == S_EXTBRK);
      end else if (byte_in == PS2_PFX_BRK) begin
        case (state_q)
          S_IDLE:  state_d = S_BRK;
          S_EXT:   state_d = S_EXTBRK;
          default: state_d = state_q;
        endcase
      end else begin
        ev_d     = 1'b1;
        ev_ext_d = (state_q == S_EXT) || (state_q == S_EXTBRK);
        ev_rel_d = (state_q == S_BRK) || (state_q == S_EXTBRK);
        state_d  = S_IDLE;
      end
    end
  end

  assign held_match = held_vld_q && (held_code_q == byte_in) && (held_ext_q == ev_ext_d);
  assign repeat_d   = ev_d && !ev_rel_d && held_match;
  assign shift_held = shift_l_q | shift_r_q;

  // Pop strobe, event fields, held-key tracking, shift state and make counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      pop_q         <= 1'b0;
      key_valid_q   <= 1'b0;
      key_code_q    <= 8'h00;
      key_ext_q     <= 1'b0;
      key_release_q <= 1'b0;
      key_repeat_q  <= 1'b0;
      proto_err_q   <= 1'b0;
      key_count_q   <= '0;
      held_code_q   <= 8'h00;
      held_ext_q    <= 1'b0;
      held_vld_q    <= 1'b0;
      shift_l_q     <= 1'b0;
      shift_r_q     <= 1'b0;
    end else begin
      pop_q       <= pop;
      key_valid_q <= ev_d;
      proto_err_q <= perr_d;
      if (ev_d) begin
        key_code_q    <= byte_in;
        key_ext_q     <= ev_ext_d;
        key_release_q <= ev_rel_d;
        key_repeat_q  <= repeat_d;
        if (ev_rel_d) begin
          if (held_match) held_vld_q <= 1'b0;
        end else if (!repeat_d) begin
          held_code_q <= byte_in;
          held_ext_q  <= ev_ext_d;
          held_vld_q  <= 1'b1;
          key_count_q <= key_count_q + COUNT_W'(1);
        end
        if (!ev_ext_d && byte_in == PS2_LSHIFT) shift_l_q <= ~ev_rel_d;
        if (!ev_ext_d && byte_in == PS2_RSHIFT) shift_r_q <= ~ev_rel_d;
      end
    end
  end

`ifdef PS2_DECODER_ASCII_EN
  logic [7:0] map_ascii;
  logic [7:0] key_ascii_q;

  // shift_held here is still the value from before this byte.
  ps2_scancode_ascii u_ascii (
    .code  (byte_in),
    .shift (shift_held),
    .ascii (map_ascii)
  );

  // ASCII code registered with the other event fields; extended keys have no mapping.
  always_ff @(posedge clk) begin
    if (rst)       key_ascii_q <= 8'h00;
    else if (ev_d) key_ascii_q <= ev_ext_d ? 8'h00 : map_ascii;
  end

  assign bus.key_ascii = key_ascii_q;
`else
  assign bus.key_ascii = 8'h00;
`endif

  assign bus.ps2_read_n  = ~pop_q;
  assign bus.key_valid   = key_valid_q;
  assign bus.key_code    = key_code_q;
  assign bus.key_ext     = key_ext_q;
  assign bus.key_release = key_release_q;
  assign bus.key_repeat  = key_repeat_q;
  assign bus.shift_held  = shift_held;
  assign bus.key_count   = key_count_q;
  assign bus.proto_err   = proto_err_q;
  assign bus.fsm_state   = state_q;

endmodule
